mem_uart_tx: RTL and testbench

MEM_UART_TX -- requirements
Module: mem_uart_tx

---
 rtl/mem_uart_pkg.sv | 27 ++
 rtl/sync_fifo.sv | 47 ++++
 rtl/mem_uart_tx.sv | 192 +++++++++++++++++++
 tb/tb_mem_uart_tx.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_uart_pkg.sv
// Shared register map, STATUS bit positions and TX state encoding for mem_uart_tx.
package mem_uart_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIV    = 2'd2;
    localparam logic [1:0] REG_NONE   = 2'd3;

    localparam int ST_BUSY    = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_EMPTY   = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_LVL_LSB = 4;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    // The STATUS level field is only three bits wide, so deeper FIFOs report 7.
    function automatic logic [2:0] sat_level(input logic [31:0] lvl);
        return (lvl > 32'd7) ? 3'd7 : lvl[2:0];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; pointers carry one extra wrap bit so full and empty differ.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_pop;
    logic             do_push;

    // A push into a full FIFO still lands when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

    assign dout  = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level = wr_ptr - rd_ptr;

endmodule

// File: rtl/mem_uart_tx.sv
// Memory-mapped UART transmitter: DATA/STATUS/DIV registers, TX FIFO and 8N1 serialiser.
module mem_uart_tx
    import mem_uart_pkg::*;
#(
    parameter logic [15:0] DIV_RESET  = 16'd104,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    output logic        uart_tx
);

    localparam int AW = $clog2(FIFO_DEPTH);

    // Handshake: mem_valid is sampled while mem_ready is low; mem_ready pulses for
    // exactly the following cycle with mem_rdata, and the master holds addr/wdata/wstrb
    // through that cycle, which is when a write takes effect.
    logic        ready_q;
    logic [31:0] rdata_q;
    logic        ovf_q;
    logic [15:0] divisor_q;

    logic [1:0]  sel;
    logic        sample;
    logic        wr_en;
    logic        push;
    logic        pop;
    logic        ovf_event;
    logic        ovf_clear;
    logic        div_wr;
    logic [15:0] div_new;
    logic [31:0] status_word;
    logic [31:0] read_data;
    logic        busy;

    logic        fifo_full;
    logic        fifo_empty;
    logic [AW:0] fifo_level;
    logic [7:0]  fifo_dout;

    tx_state_t   tx_state;
    tx_state_t   state_d;
    logic [15:0] bit_cnt_q, bit_cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [15:0] div_lat_q, div_lat_d;
    logic        bit_end;

    logic unused_bits;
    assign unused_bits = ^{mem_addr[31:4], mem_addr[1:0], mem_wdata[31:16], mem_wstrb[3:2]};

    assign sel       = mem_addr[3:2];
    assign sample    = mem_valid && !ready_q;
    assign wr_en     = ready_q && mem_valid && (mem_wstrb != 4'b0000);
    assign push      = wr_en && (sel == REG_DATA) && mem_wstrb[0];
    assign ovf_event = push && fifo_full && !pop;
    assign ovf_clear = wr_en && (sel == REG_STATUS) && mem_wstrb[0] && mem_wdata[3];
    assign div_wr    = wr_en && (sel == REG_DIV);
    assign busy      = (tx_state != TX_IDLE);

    always_comb begin
        div_new = divisor_q;
        if (mem_wstrb[0]) div_new[7:0]  = mem_wdata[7:0];
        if (mem_wstrb[1]) div_new[15:8] = mem_wdata[15:8];
        if (div_new == 16'd0) div_new = 16'd1;
    end

    always_comb begin
        status_word                       = '0;
        status_word[ST_BUSY]              = busy;
        status_word[ST_FULL]              = fifo_full;
        status_word[ST_EMPTY]             = fifo_empty;
        status_word[ST_OVF]               = ovf_q;
        status_word[ST_LVL_LSB +: 3]      = sat_level(32'(fifo_level));
    end

    always_comb begin
        read_data = '0;
        case (sel)
            REG_STATUS: read_data = status_word;
            REG_DIV:    read_data = {16'b0, divisor_q};
            default:    read_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q   <= 1'b0;
            rdata_q   <= '0;
            ovf_q     <= 1'b0;
            divisor_q <= DIV_RESET;
        end else begin
            ready_q <= sample;
            rdata_q <= sample ? read_data : '0;
            if (ovf_event)      ovf_q <= 1'b1;
            else if (ovf_clear) ovf_q <= 1'b0;
            if (div_wr) divisor_q <= div_new;
        end
    end

    assign mem_ready = ready_q;
    assign mem_rdata = rdata_q;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (mem_wdata[7:0]),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state  <= TX_IDLE;
            bit_cnt_q <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            div_lat_q <= 16'd1;
        end else begin
            tx_state  <= state_d;
            bit_cnt_q <= bit_cnt_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            div_lat_q <= div_lat_d;
        end
    end

    // The divisor is latched at pop so DIV writes only affect later frames.
    assign bit_end = (bit_cnt_q == div_lat_q - 16'd1);

    always_comb begin
        state_d   = tx_state;
        bit_cnt_d = bit_cnt_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        div_lat_d = div_lat_q;
        pop       = 1'b0;
        uart_tx   = 1'b1;
        case (tx_state)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    shreg_d   = fifo_dout;
                    div_lat_d = divisor_q;
                    bit_cnt_d = '0;
                    state_d   = TX_START;
                end
            end
            TX_START: begin
                uart_tx = 1'b0;
                if (bit_end) begin
                    bit_cnt_d = '0;
                    bit_idx_d = '0;
                    state_d   = TX_DATA;
                end else begin
                    bit_cnt_d = bit_cnt_q + 16'd1;
                end
            end
            TX_DATA: begin
                uart_tx = shreg_q[0];
                if (bit_end) begin
                    bit_cnt_d = '0;
                    shreg_d   = {1'b0, shreg_q[7:1]};
                    if (bit_idx_q == 3'd7) state_d = TX_STOP;
                    else bit_idx_d = bit_idx_q + 3'd1;
                end else begin
                    bit_cnt_d = bit_cnt_q + 16'd1;
                end
            end
            TX_STOP: begin
                if (bit_end) begin
                    bit_cnt_d = '0;
                    state_d   = TX_IDLE;
                end else begin
                    bit_cnt_d = bit_cnt_q + 16'd1;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_uart_tx.sv
// Randomised self-checking bench for mem_uart_tx against a frame-level reference model.
module tb_mem_uart_tx;

    localparam int DEPTH = 4;
    localparam logic [31:0] DATA_A   = 32'h0000_0000;
    localparam logic [31:0] STATUS_A = 32'h0000_0004;
    localparam logic [31:0] DIV_A    = 32'h0000_0008;
    localparam logic [31:0] NONE_A   = 32'h0000_000C;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_valid = 1'b0;
    logic        mem_ready;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  mem_wstrb = '0;
    logic [31:0] mem_rdata;
    logic        uart_tx;

    always #5 clk = ~clk;

    mem_uart_tx #(.DIV_RESET(16'd104), .FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata),
        .uart_tx   (uart_tx)
    );

    int     checks = 0;
    int     failures = 0;
    longint cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: bytes waiting to be sent, plus the frame currently on the line.
    logic [7:0]  exp_q[$];
    logic        m_ovf = 1'b0;
    logic [15:0] m_div = 16'd104;
    longint      m_free = 0;
    longint      m_fs = -1000;
    longint      m_fd = 1;
    logic [7:0]  m_fb = '0;
    logic        m_ready = 1'b0;
    logic [31:0] m_rdata = '0;

    logic        s_smp, s_wr, s_pop, s_ovf, s_busy;
    logic [1:0]  s_sel;
    int          s_size;
    logic [31:0] s_rn;
    logic [15:0] s_nd;
    logic [2:0]  s_lvl;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            m_ovf   = 1'b0;
            m_div   = 16'd104;
            m_free  = 0;
            m_fs    = -1000;
            m_fd    = 1;
            m_ready = 1'b0;
            m_rdata = '0;
        end else begin
            cyc    = cyc + 1;
            s_smp  = mem_valid && !m_ready;
            s_wr   = m_ready && mem_valid && (mem_wstrb != 4'b0000);
            s_sel  = mem_addr[3:2];
            s_size = exp_q.size();
            s_busy = (cyc < m_free);
            s_lvl  = (s_size > 7) ? 3'd7 : 3'(s_size);
            case (s_sel)
                2'd1:    s_rn = {24'b0, 1'b0, s_lvl, m_ovf, (s_size == 0), (s_size == DEPTH), s_busy};
                2'd2:    s_rn = {16'b0, m_div};
                default: s_rn = '0;
            endcase
            s_pop = 1'b0;
            if (cyc >= m_free && s_size > 0) begin
                m_fb   = exp_q.pop_front();
                m_fd   = longint'(m_div);
                m_fs   = cyc;
                m_free = cyc + 10 * m_fd + 1;
                s_pop  = 1'b1;
            end
            s_ovf = 1'b0;
            if (s_wr && s_sel == 2'd0 && mem_wstrb[0]) begin
                if (s_size < DEPTH || s_pop) exp_q.push_back(mem_wdata[7:0]);
                else s_ovf = 1'b1;
            end
            if (s_ovf) m_ovf = 1'b1;
            else if (s_wr && s_sel == 2'd1 && mem_wstrb[0] && mem_wdata[3]) m_ovf = 1'b0;
            if (s_wr && s_sel == 2'd2) begin
                s_nd = m_div;
                if (mem_wstrb[0]) s_nd[7:0]  = mem_wdata[7:0];
                if (mem_wstrb[1]) s_nd[15:8] = mem_wdata[15:8];
                if (s_nd == 16'd0) s_nd = 16'd1;
                m_div = s_nd;
            end
            m_ready = s_smp;
            if (s_smp) m_rdata = s_rn;
        end
    end

    // Line level in cycle c: start 0, data LSB first, stop 1, each m_fd cycles.
    function automatic logic exp_line(input longint c);
        longint k;
        if (c >= m_fs && c < m_fs + 10 * m_fd) begin
            k = (c - m_fs) / m_fd;
            if (k == 0) return 1'b0;
            if (k <= 8) return m_fb[int'(k) - 1];
        end
        return 1'b1;
    endfunction

    longint fall_q[$];
    logic   prev_tx = 1'b1;

    always @(negedge clk) begin
        if (rst_n) begin
            check("mem_ready", {31'b0, mem_ready}, {31'b0, m_ready});
            if (m_ready) check("mem_rdata", mem_rdata, m_rdata);
            check("uart_tx", {31'b0, uart_tx}, {31'b0, exp_line(cyc)});
            if (prev_tx && !uart_tx) fall_q.push_back(cyc);
            prev_tx = uart_tx;
        end else begin
            prev_tx = 1'b1;
        end
    end

    task automatic bus_xfer(input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] wstrb, output logic [31:0] rdata);
        logic got;
        got   = 1'b0;
        rdata = '0;
        mem_valid = 1'b1;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_wstrb = wstrb;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (mem_ready) begin
                got   = 1'b1;
                rdata = mem_rdata;
            end
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL bus_handshake: mem_ready=0 after 8 cycles, required 1 (cycle %0d)", cyc);
        end
        @(negedge clk);
        mem_valid = 1'b0;
        mem_wstrb = '0;
    endtask

    task automatic wait_idle();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 5000 && !done; i++) begin
            @(negedge clk);
            if (cyc > m_free && exp_q.size() == 0) done = 1'b1;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL wait_idle: transmitter still busy after 5000 cycles, required idle");
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    logic [31:0] rd;
    logic [31:0] a;
    logic [9:0]  pat;
    logic        seen;
    int          sel;
    localparam logic [9:0] A5_FRAME = 10'b0101001011;

    initial begin
        repeat (3) @(negedge clk);
        check("reset_ready", {31'b0, mem_ready}, 32'd0);
        check("reset_rdata", mem_rdata, 32'd0);
        check("reset_tx", {31'b0, uart_tx}, 32'd1);
        rst_n = 1'b1;

        bus_xfer(STATUS_A, 32'd0, 4'b0000, rd);
        check("reset_status", rd, 32'h0000_0004);
        bus_xfer(DIV_A, 32'd0, 4'b0000, rd);
        check("reset_div", rd, 32'h0000_0068);
        check("idle_tx", {31'b0, uart_tx}, 32'd1);

        // 0xA5 frame at 4 clocks per bit, sampled mid-bit
        bus_xfer(DIV_A, 32'd4, 4'b0011, rd);
        bus_xfer(DATA_A, 32'h0000_00A5, 4'b0001, rd);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (!uart_tx) seen = 1'b1;
        end
        check("a5_start_seen", {31'b0, seen}, 32'd1);
        pat = '0;
        for (int i = 0; i < 40; i++) begin
            if (i % 4 == 2) pat = {pat[8:0], uart_tx};
            @(negedge clk);
        end
        check("a5_frame", {22'b0, pat}, {22'b0, A5_FRAME});
        wait_idle();

        // six back-to-back bytes into a 4-deep FIFO at divisor 2
        bus_xfer(DIV_A, 32'd2, 4'b0001, rd);
        fall_q.delete();
        for (int i = 0; i < 6; i++)
            bus_xfer(DATA_A, (i % 2 == 0) ? 32'h00 : 32'hFF, 4'b0001, rd);
        bus_xfer(STATUS_A, 32'd0, 4'b0000, rd);
        check("overflow_set", {31'b0, rd[3]}, 32'd1);
        wait_idle();
        check("frames_sent", fall_q.size(), 32'd5);
        for (int i = 1; i < fall_q.size(); i++)
            check("start_spacing_div2", 32'(fall_q[i] - fall_q[i-1]), 32'd21);

        bus_xfer(STATUS_A, 32'h8, 4'b0001, rd);
        mem_valid = 1'b1;
        mem_addr  = STATUS_A;
        mem_wstrb = 4'b0000;
        check("hold_ready_c0", {31'b0, mem_ready}, 32'd0);
        @(negedge clk);
        check("hold_ready_c1", {31'b0, mem_ready}, 32'd1);
        check("overflow_cleared", {31'b0, mem_rdata[3]}, 32'd0);
        @(negedge clk);
        check("hold_ready_c2", {31'b0, mem_ready}, 32'd0);
        mem_valid = 1'b0;
        @(negedge clk);

        bus_xfer(DIV_A, 32'd0, 4'b0011, rd);
        bus_xfer(DIV_A, 32'd0, 4'b0000, rd);
        check("div_zero_is_one", rd, 32'h0000_0001);
        bus_xfer(DIV_A, 32'd4, 4'b0011, rd);
        fall_q.delete();
        bus_xfer(DATA_A, 32'h00, 4'b0001, rd);
        bus_xfer(DATA_A, 32'hFF, 4'b0001, rd);
        bus_xfer(DIV_A, 32'd8, 4'b0011, rd);
        wait_idle();
        check("midframe_div_frames", fall_q.size(), 32'd2);
        if (fall_q.size() == 2)
            check("midframe_div_spacing", 32'(fall_q[1] - fall_q[0]), 32'd41);

        // reset while inside the data bits
        bus_xfer(DIV_A, 32'd4, 4'b0011, rd);
        bus_xfer(DATA_A, 32'h0000_00A5, 4'b0001, rd);
        @(negedge clk);
        bus_xfer(STATUS_A, 32'd0, 4'b0000, rd);
        check("busy_in_frame", {31'b0, rd[0]}, 32'd1);
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("reset_abort_tx", {31'b0, uart_tx}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus_xfer(STATUS_A, 32'd0, 4'b0000, rd);
        check("status_after_abort", rd, 32'h0000_0004);

        bus_xfer(DIV_A, 32'd3, 4'b0011, rd);
        for (int n = 0; n < 180; n++) begin
            sel = $urandom_range(0, 9);
            a = $urandom;
            a[3:2] = (sel <= 3 || sel == 9) ? 2'd0 : (sel <= 5) ? 2'd1 : (sel <= 7) ? 2'd2 : 2'd3;
            bus_xfer(a, (a[3:2] == 2'd2) ? 32'($urandom_range(0, 5)) : $urandom,
                     ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom_range(1, 15)), rd);
            repeat ($urandom_range(0, 4)) @(negedge clk);
            if ($urandom_range(0, 15) == 0) repeat (40) @(negedge clk);
        end
        bus_xfer(NONE_A, 32'hFFFF_FFFF, 4'b1111, rd);
        bus_xfer(NONE_A, 32'd0, 4'b0000, rd);
        check("unmapped_read", rd, 32'd0);
        wait_idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
